// File: rtl/alarm_buzz_ctrl.sv
// Buzzer controller behind the alarm clock core: beep pattern, snooze and auto-timeout.
// Optional snooze support is built only when ALARM_BUZZ_SNOOZE_EN is defined.
module alarm_buzz_ctrl #(
  parameter int BEEP_ON      = 1,
  parameter int BEEP_OFF     = 1,
  parameter int SNOOZE_SECS  = 540,
  parameter int TIMEOUT_SECS = 120,
  parameter int MAX_SNOOZE   = 3
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Tick,
  input  logic       Buzz_in,
  input  logic       Alarmon,
  input  logic       Snooze,
  output logic       Beep,
  output logic       Ringing,
  output logic       Snoozing,
  output logic [1:0] Snooze_cnt
);

  localparam int PERIOD = BEEP_ON + BEEP_OFF;
  localparam int PH_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int RG_W   = (TIMEOUT_SECS > 1) ? $clog2(TIMEOUT_SECS) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD - 1);
  localparam logic [RG_W-1:0] RG_LAST = RG_W'(TIMEOUT_SECS - 1);

`ifdef ALARM_BUZZ_SNOOZE_EN
  localparam int SZ_W = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS) : 1;
  localparam logic [SZ_W-1:0] SZ_LAST = SZ_W'(SNOOZE_SECS - 1);
  localparam logic [1:0]      MAX_C   = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RING   = 2'd1,
    S_SNOOZE = 2'd2,
    S_DONE   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RING = 2'd1,
    S_DONE = 2'd3
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [RG_W-1:0] ring_q, ring_d;
  logic            buzz_q;
  logic            beep_q, beep_d;
  logic            ringing_q, ringing_d;
  logic            buzz_rise;

`ifdef ALARM_BUZZ_SNOOZE_EN
  logic [SZ_W-1:0] snz_q, snz_d;
  logic [1:0]      used_q, used_d;
  logic            snooze_q;
  logic            snoozing_q, snoozing_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            snooze_rise;
`else
  logic            unused_snooze;
  assign unused_snooze = Snooze ^ (SNOOZE_SECS != 0) ^ (MAX_SNOOZE != 0);
`endif

  assign buzz_rise = Buzz_in & ~buzz_q;
`ifdef ALARM_BUZZ_SNOOZE_EN
  assign snooze_rise = Snooze & ~snooze_q;
`endif

  // Next-state and counter logic; Alarmon low overrides everything.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    ring_d  = ring_q;
`ifdef ALARM_BUZZ_SNOOZE_EN
    snz_d   = snz_q;
    used_d  = used_q;
`endif
    if (!Alarmon) begin
      state_d = S_IDLE;
      phase_d = '0;
      ring_d  = '0;
`ifdef ALARM_BUZZ_SNOOZE_EN
      snz_d   = '0;
      used_d  = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (buzz_rise) begin
            state_d = S_RING;
            phase_d = '0;
            ring_d  = '0;
`ifdef ALARM_BUZZ_SNOOZE_EN
            used_d  = '0;
`endif
          end
        end
        S_RING: begin
`ifdef ALARM_BUZZ_SNOOZE_EN
          if (snooze_rise && (used_q < MAX_C)) begin
            state_d = S_SNOOZE;
            used_d  = used_q + 2'd1;
            snz_d   = '0;
          end else
`endif
          if (Tick) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
            if (ring_q == RG_LAST) begin
              state_d = S_DONE;
              ring_d  = '0;
            end else begin
              ring_d  = ring_q + 1'b1;
            end
          end
        end
`ifdef ALARM_BUZZ_SNOOZE_EN
        S_SNOOZE: begin
          if (Tick) begin
            if (snz_q == SZ_LAST) begin
              state_d = S_RING;
              snz_d   = '0;
              phase_d = '0;
              ring_d  = '0;
            end else begin
              snz_d   = snz_q + 1'b1;
            end
          end
        end
`endif
        S_DONE: begin
          if (!Buzz_in) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Moore output decode, registered one edge behind the state.
  always_comb begin
    ringing_d  = (state_q == S_RING);
    beep_d     = (state_q == S_RING) && (32'(phase_q) < BEEP_ON);
`ifdef ALARM_BUZZ_SNOOZE_EN
    snoozing_d = (state_q == S_SNOOZE);
    cnt_d      = used_q;
`endif
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      ring_q     <= '0;
      buzz_q     <= 1'b0;
      beep_q     <= 1'b0;
      ringing_q  <= 1'b0;
`ifdef ALARM_BUZZ_SNOOZE_EN
      snz_q      <= '0;
      used_q     <= '0;
      snooze_q   <= 1'b0;
      snoozing_q <= 1'b0;
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      ring_q     <= ring_d;
      buzz_q     <= Buzz_in;
      beep_q     <= beep_d;
      ringing_q  <= ringing_d;
`ifdef ALARM_BUZZ_SNOOZE_EN
      snz_q      <= snz_d;
      used_q     <= used_d;
      snooze_q   <= Snooze;
      snoozing_q <= snoozing_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign Beep    = beep_q;
  assign Ringing = ringing_q;
`ifdef ALARM_BUZZ_SNOOZE_EN
  assign Snoozing   = snoozing_q;
  assign Snooze_cnt = cnt_q;
`else
  assign Snoozing   = 1'b0;
  assign Snooze_cnt = 2'b00;
`endif

endmodule

// File: tb/tb_alarm_buzz_ctrl.sv
// Directed bench for alarm_buzz_ctrl: reset, beep pattern/timeout, snooze, priority.
module tb_alarm_buzz_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Tick = 1'b0;
  logic       Buzz_in = 1'b0;
  logic       Alarmon = 1'b0;
  logic       Snooze = 1'b0;
  logic       Beep;
  logic       Ringing;
  logic       Snoozing;
  logic [1:0] Snooze_cnt;

  int checks = 0;
  int failures = 0;

  alarm_buzz_ctrl #(
    .BEEP_ON(1), .BEEP_OFF(1), .SNOOZE_SECS(4), .TIMEOUT_SECS(6), .MAX_SNOOZE(2)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Tick(Tick), .Buzz_in(Buzz_in),
    .Alarmon(Alarmon), .Snooze(Snooze), .Beep(Beep), .Ringing(Ringing),
    .Snoozing(Snoozing), .Snooze_cnt(Snooze_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // One second = 4 clocks; returns one edge after the Tick edge.
  task automatic sec();
    step(2);
    Tick = 1'b1;
    step(1);
    Tick = 1'b0;
    step(1);
  endtask

  task automatic start_ring();
    Buzz_in = 1'b1;
    step(2);
    Buzz_in = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    Alarmon = 1'b1;
    Buzz_in = 1'b1;
    step(3);
    checks++;
    if ({Beep, Ringing, Snoozing, Snooze_cnt} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b want 00000", {Beep, Ringing, Snoozing, Snooze_cnt});
    end
    Buzz_in = 1'b0;
    Reset_n = 1'b1;
    step(2);
    checks++;
    if ({Beep, Ringing, Snoozing, Snooze_cnt} !== 5'b0) begin
      failures++;
      $display("FAIL post_reset_idle: got %b want 00000", {Beep, Ringing, Snoozing, Snooze_cnt});
    end
  endtask

  task automatic test_pattern_timeout();
    logic exp_beep;
    Buzz_in = 1'b1;
    step(1);
    checks++;
    if (Ringing !== 1'b0) begin
      failures++;
      $display("FAIL ring_latency_1edge: got %b want 0", Ringing);
    end
    step(1);
    checks++;
    if ({Ringing, Beep} !== 2'b11) begin
      failures++;
      $display("FAIL ring_latency_2edge: got %b want 11", {Ringing, Beep});
    end
    for (int k = 1; k <= 6; k++) begin
      sec();
      exp_beep = (k < 6) && (k % 2 == 0);
      checks++;
      if ({Ringing, Beep} !== {(k < 6), exp_beep}) begin
        failures++;
        $display("FAIL pattern_tick%0d: got ring/beep %b want %b", k, {Ringing, Beep}, {(k < 6), exp_beep});
      end
    end
    step(12);
    checks++;
    if (Ringing !== 1'b0) begin
      failures++;
      $display("FAIL no_retrigger_held: got %b want 0", Ringing);
    end
    Buzz_in = 1'b0;
    step(2);
    Buzz_in = 1'b1;
    step(2);
    checks++;
    if ({Ringing, Beep} !== 2'b11) begin
      failures++;
      $display("FAIL rering_after_drop: got %b want 11", {Ringing, Beep});
    end
    Buzz_in = 1'b0;
    Alarmon = 1'b0;
    step(2);
    Alarmon = 1'b1;
    step(1);
  endtask

  task automatic test_priority_ring();
    start_ring();
    sec();
    Alarmon = 1'b0;
    step(1);
    checks++;
    if (Ringing !== 1'b1) begin
      failures++;
      $display("FAIL alarmoff_latency_1edge: got %b want 1", Ringing);
    end
    step(1);
    checks++;
    if ({Beep, Ringing, Snoozing, Snooze_cnt} !== 5'b0) begin
      failures++;
      $display("FAIL alarmoff_ring: got %b want 00000", {Beep, Ringing, Snoozing, Snooze_cnt});
    end
    Buzz_in = 1'b1;
    step(3);
    checks++;
    if (Ringing !== 1'b0) begin
      failures++;
      $display("FAIL buzz_while_disabled: got %b want 0", Ringing);
    end
    Buzz_in = 1'b0;
    Alarmon = 1'b1;
    step(2);
  endtask

  task automatic test_async_reset();
    start_ring();
    checks++;
    if (Ringing !== 1'b1) begin
      failures++;
      $display("FAIL async_pre_ring: got %b want 1", Ringing);
    end
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({Beep, Ringing} !== 2'b00) begin
      failures++;
      $display("FAIL async_reset: got %b want 00", {Beep, Ringing});
    end
    Reset_n = 1'b1;
    step(2);
    checks++;
    if (Ringing !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_idle: got %b want 0", Ringing);
    end
  endtask

`ifdef ALARM_BUZZ_SNOOZE_EN
  task automatic test_snooze();
    start_ring();
    Snooze = 1'b1;
    step(1);
    Snooze = 1'b0;
    step(1);
    checks++;
    if ({Ringing, Snoozing, Beep, Snooze_cnt} !== 5'b01001) begin
      failures++;
      $display("FAIL snooze_enter: got %b want 01001", {Ringing, Snoozing, Beep, Snooze_cnt});
    end
    for (int k = 1; k <= 4; k++) begin
      sec();
      checks++;
      if ({Ringing, Snoozing} !== {(k == 4), (k < 4)}) begin
        failures++;
        $display("FAIL snooze_tick%0d: got ring/snz %b want %b", k, {Ringing, Snoozing}, {(k == 4), (k < 4)});
      end
    end
    checks++;
    if ({Beep, Snooze_cnt} !== 3'b101) begin
      failures++;
      $display("FAIL snooze_return: got beep/cnt %b want 101", {Beep, Snooze_cnt});
    end
  endtask

  task automatic test_snooze_limit();
    Snooze = 1'b1;
    step(1);
    Snooze = 1'b0;
    step(1);
    checks++;
    if ({Snoozing, Snooze_cnt} !== 3'b110) begin
      failures++;
      $display("FAIL snooze2: got %b want 110", {Snoozing, Snooze_cnt});
    end
    repeat (4) sec();
    Snooze = 1'b1;
    step(1);
    Snooze = 1'b0;
    step(1);
    checks++;
    if ({Ringing, Snoozing, Snooze_cnt} !== 4'b1010) begin
      failures++;
      $display("FAIL snooze3_ignored: got %b want 1010", {Ringing, Snoozing, Snooze_cnt});
    end
    repeat (5) sec();
    checks++;
    if (Ringing !== 1'b1) begin
      failures++;
      $display("FAIL limit_tick5: got %b want 1", Ringing);
    end
    sec();
    checks++;
    if ({Ringing, Beep} !== 2'b00) begin
      failures++;
      $display("FAIL limit_timeout: got %b want 00", {Ringing, Beep});
    end
    step(2);
  endtask

  task automatic test_priority_snooze();
    start_ring();
    checks++;
    if (Snooze_cnt !== 2'd0) begin
      failures++;
      $display("FAIL new_episode_cnt: got %0d want 0", Snooze_cnt);
    end
    Snooze = 1'b1;
    step(1);
    Snooze = 1'b0;
    step(1);
    Alarmon = 1'b0;
    step(1);
    checks++;
    if (Snoozing !== 1'b1) begin
      failures++;
      $display("FAIL snz_off_latency: got %b want 1", Snoozing);
    end
    step(1);
    checks++;
    if ({Beep, Ringing, Snoozing, Snooze_cnt} !== 5'b0) begin
      failures++;
      $display("FAIL alarmoff_snooze: got %b want 00000", {Beep, Ringing, Snoozing, Snooze_cnt});
    end
    Alarmon = 1'b1;
    step(2);
  endtask

  task automatic test_coincident();
    start_ring();
    repeat (5) sec();
    step(2);
    Tick = 1'b1;
    Snooze = 1'b1;
    step(1);
    Tick = 1'b0;
    Snooze = 1'b0;
    step(1);
    checks++;
    if ({Ringing, Snoozing, Snooze_cnt} !== 4'b0101) begin
      failures++;
      $display("FAIL snooze_vs_timeout: got %b want 0101", {Ringing, Snoozing, Snooze_cnt});
    end
    Alarmon = 1'b0;
    step(2);
    Alarmon = 1'b1;
    step(1);
  endtask
`else
  task automatic test_snooze_disabled();
    start_ring();
    Snooze = 1'b1;
    step(1);
    Snooze = 1'b0;
    step(1);
    checks++;
    if ({Ringing, Snoozing, Snooze_cnt} !== 4'b1000) begin
      failures++;
      $display("FAIL nosnz_press: got %b want 1000", {Ringing, Snoozing, Snooze_cnt});
    end
    repeat (5) sec();
    checks++;
    if (Ringing !== 1'b1) begin
      failures++;
      $display("FAIL nosnz_tick5: got %b want 1", Ringing);
    end
    sec();
    checks++;
    if ({Ringing, Snoozing, Snooze_cnt} !== 4'b0000) begin
      failures++;
      $display("FAIL nosnz_timeout: got %b want 0000", {Ringing, Snoozing, Snooze_cnt});
    end
    step(2);
  endtask
`endif

  initial begin
    test_reset();
    test_pattern_timeout();
    test_priority_ring();
`ifdef ALARM_BUZZ_SNOOZE_EN
    test_snooze();
    test_snooze_limit();
    test_priority_snooze();
    test_coincident();
`else
    test_snooze_disabled();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
